// File: rtl/hazard_interlock_ctrl.sv
// hazard_interlock_ctrl
//   Pipeline sequencing controller for the 5-stage DLX core, sitting beside ID.
//   Detects load-use and (without forwarding) RAW hazards against EX/MEM, handles
//   taken-branch squashes, and freezes the front end while a multiply occupies EX.
//   Optional feature macro: HAZARD_FWD_EN (registered forward selects, only
//   load-use stalls). Undefined: fwd_a/fwd_b stay 00 and any EX/MEM RAW stalls.
// Parameters
//   MUL_CYCLES  cycles a multiply occupies EX (1..15)
//   CNT_W       width of the saturating stall-cycle counter
// Ports
//   clk, reset                      clock, async active-high reset
//   id_*                            ID-stage instruction info
//   ex_*, mem_*                     in-flight EX/MEM destination info
//   ex_taken                        branch/jump resolved taken in EX
//   pc_write, ifid_write, idex_write, idex_bubble, flush_ifid, exmem_bubble,
//   mul_busy                        pipeline control, decided from state + inputs
//   fwd_a, fwd_b                    registered forward selects for instr in EX
//   stall_cycles                    saturating count of cycles with pc_write=0
module hazard_interlock_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_mul,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_rd,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic             ex_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             exmem_bubble,
  output logic             mul_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MC_W = 4;

  typedef enum logic {RUN, MUL_BUSY} state_t;

  state_t          state;
  logic [MC_W-1:0] mul_cnt;
  logic            issue;
  logic            load_use;
  logic            raw_stall;
  logic [1:0]      fwd_a_nxt;
  logic [1:0]      fwd_b_nxt;

  // ID reads register r (R0 never hazards)
  function automatic logic match(input logic [4:0] r, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1,
                                 input logic u2);
    return (r != 5'd0) && ((u1 && rs1 == r) || (u2 && rs2 == r));
  endfunction

  // Forward select for one source: EX/MEM result wins over MEM/WB
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_valid && ex_regwrite && ex_rd != 5'd0 && rs == ex_rd)
      sel = 2'b01;
    else if (mem_valid && mem_regwrite && mem_rd != 5'd0 && rs == mem_rd)
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    load_use = id_valid && ex_valid && ex_memtoreg &&
               match(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
`ifdef HAZARD_FWD_EN
    raw_stall = 1'b0;
    fwd_a_nxt = fwd_sel(id_rs1);
    fwd_b_nxt = fwd_sel(id_rs2);
`else
    raw_stall = id_valid &&
      ((ex_valid && ex_regwrite && match(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2)) ||
       (mem_valid && mem_regwrite && match(mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2)));
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
`endif
  end

  // Priority decision; reset forces the free-running defaults
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    flush_ifid   = 1'b0;
    exmem_bubble = 1'b0;
    mul_busy     = 1'b0;
    issue        = 1'b0;
    if (!reset) begin
      if (state == MUL_BUSY) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        mul_busy     = 1'b1;
      end else if (ex_taken) begin
        flush_ifid  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use || raw_stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else begin
        issue = 1'b1;
      end
    end
  end

  // State, multiply counter, forward selects and stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      mul_cnt      <= '0;
      fwd_a        <= 2'b00;
      fwd_b        <= 2'b00;
      stall_cycles <= '0;
    end else begin
      if (state == MUL_BUSY) begin
        mul_cnt <= mul_cnt - MC_W'(1);
        if (mul_cnt == MC_W'(1)) state <= RUN;
      end else if (issue && id_valid && id_mul && MUL_CYCLES > 1) begin
        mul_cnt <= MC_W'(MUL_CYCLES - 1);
        state   <= MUL_BUSY;
      end

      if (idex_bubble) begin
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else if (issue) begin
        fwd_a <= fwd_a_nxt;
        fwd_b <= fwd_b_nxt;
      end

      if (!pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
